event_encoder_16x4: RTL and testbench
=====================================

# event_encoder_16x4

Sequential 16-to-4 encoder that latches one-hot or multi-hot event flags into a pending register. It emits the 4-bit index of each pending flag, lowest index first, one code per valid/ready transfer. It is the encode-side counterpart of the team's 4-to-16 decoder and sits between event sources and any consumer that expects a binary channel number. Every event gets its own code, so simultaneous flags are serialized, not lost.

## Interface
- IN_WIDTH, 16, number of event flags. Fixed at 16 for this block.
- OUT_WIDTH, 4, code width. Must equal log2(IN_WIDTH).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- enable  input  1  when 0, req_in is ignored. Draining of already-pending events continues.
- req_in  input  16  event flags, sampled every cycle. Bit i set means event i occurred.
- ready_in  input  1  consumer accepts binary_out this cycle.
- binary_out  output  4  index of the event being presented.
- valid_out  output  1  binary_out holds a valid code.
- pending_out  output  16  registered pending flags, not yet presented.
- overflow_out  output  1  one-cycle pulse: an event arrived for a bit already pending and was merged.

## Operation
- Pending register update per edge: pending <= (pending & ~clr) | (req_in & {16{enable}}).
  - clr is the one-hot of the index loaded into the output register this edge, otherwise 0.
- Selection uses only the registered pending value, never the same-cycle req_in.
- Selection is the lowest set index, computed by a combinational priority encoder.
- FSM states:
  - IDLE: valid_out=0. If pending!=0, load binary_out<=lowest index, clear that pending bit, set valid_out<=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: valid_out=1. If ready_in=0, hold binary_out and stay. If ready_in=1 and pending!=0, load the next lowest index in the same edge and stay in HOLD (back-to-back). If ready_in=1 and pending==0, set valid_out<=0 and go to IDLE.
- Set wins over clear: if req_in[i] arrives on the same edge that bit i is loaded, pending[i] stays 1. This is a new event, not an overflow.
- Overflow: req_in[i]&enable&pending[i] while bit i is not being cleared this edge sets overflow_out<=1 for exactly one cycle. The event is merged, not queued twice.
- A request for the index currently held in binary_out is not an overflow; it sets pending.
- No arithmetic beyond the index encoding. Codes are always in the range 0..15.

## Timing
- Reset values: binary_out=4'h0, valid_out=0, pending_out=16'h0000, overflow_out=0, state=IDLE.
- Reset mid-operation: all pending events and the presented code are dropped immediately, asynchronously.
- Latency: req_in high at edge k is captured into pending at k. valid_out and binary_out are registered at k+1, so the output appears 2 edges after req_in is presented.
- Throughput: one code per cycle while ready_in=1.
- A transfer occurs on an edge where valid_out&ready_in=1.
- binary_out is stable while valid_out=1 and ready_in=0.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package encoder_pkg holds:
  - IN_WIDTH and OUT_WIDTH constants.
  - FSM state encoding: IDLE=1'b0, HOLD=1'b1.
- One sub-module, priority_encoder_16x4: purely combinational.
  - Outputs: lowest set index (4 bits) and any_set flag.
  - Reused by later blocks.
- Top level contains the pending register, FSM, output register and overflow logic.

## Test plan
- Reset: assert rst with pending and valid active → all outputs 0 at once. Release → outputs stay 0 until req_in.
- Single event: req_in=16'h0001 for one cycle, ready_in=1 → 2 edges later valid_out=1, binary_out=4'h0 for exactly one cycle; pending_out returns to 16'h0000.
- Multi-hot ordering: req_in=16'h8421 for one cycle, ready_in=1 → binary_out 4'h0, 4'h5, 4'hA, 4'hF on 4 consecutive cycles, then valid_out=0.
- Backpressure: req_in=16'h0300, ready_in=0 → binary_out=4'h8 held for 5+ cycles with pending_out=16'h0200. Raise ready_in → 4'h9 on the next edge, then IDLE.
- Overflow/merge: req_in=16'h0030, ready_in=0; after capture pulse req_in=16'h0020 → overflow_out=1 for one cycle. Only one code 4'h5 is ever emitted.
- Enable gating and simultaneous set/clear:
  - enable=0 with req_in=16'hFFFF → no valid_out.
  - req_in[3] on the edge that loads code 4'h3 → 4'h3 is presented twice and overflow_out stays 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and FSM encoding for the event encoder family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package encoder_pkg;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One-hot mask of a binary index, used to clear the pending bit being loaded.
    function automatic logic [IN_WIDTH-1:0] idx_to_onehot(input logic [OUT_WIDTH-1:0] idx);
        logic [IN_WIDTH-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/priority_encoder_16x4.sv
// Combinational lowest-index priority encoder, 16 flags to a 4-bit index.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   req_i     16-bit flag vector
//   idx_o     index of lowest set flag (0 when nothing is set)
//   any_set_o 1 when at least one flag is set
module priority_encoder_16x4
    import encoder_pkg::*;
(
    input  logic [IN_WIDTH-1:0]  req_i,
    output logic [OUT_WIDTH-1:0] idx_o,
    output logic                 any_set_o
);

    always_comb begin
        idx_o     = '0;
        any_set_o = |req_i;
        // Scan downwards so the last hit written is the lowest set index.
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = i[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/event_encoder_16x4.sv
// Latches 16 event flags into a pending set and serializes them as 4-bit codes, lowest first.
// Latency: req_in at edge k lands in pending at k, code presented on valid_out after edge k+1.
// Backpressure: valid/ready; code held stable while ready_in=0, new events keep accumulating.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   enable        gates req_in capture (draining continues when low)
//   req_in        event flags, sampled every cycle
//   ready_in      consumer accepts binary_out this cycle
//   binary_out    presented event index
//   valid_out     binary_out holds a valid code
//   pending_out   events captured but not yet presented
//   overflow_out  one-cycle pulse when an event merges into an already pending bit
module event_encoder_16x4
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  req_in,
    input  logic                 ready_in,
    output logic [OUT_WIDTH-1:0] binary_out,
    output logic                 valid_out,
    output logic [IN_WIDTH-1:0]  pending_out,
    output logic                 overflow_out
);

    state_e               state_q;
    logic [OUT_WIDTH-1:0] bin_q;
    logic                 vld_q;
    logic [IN_WIDTH-1:0]  pend_q;
    logic [IN_WIDTH-1:0]  pend_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic [OUT_WIDTH-1:0] sel_idx;
    logic                 sel_any;
    logic                 load;
    logic [IN_WIDTH-1:0]  clr;
    logic [IN_WIDTH-1:0]  set;

    // Selection looks only at the registered pending set.
    priority_encoder_16x4 u_prio (
        .req_i     (pend_q),
        .idx_o     (sel_idx),
        .any_set_o (sel_any)
    );

    // The output slot can take a new code when empty or when its code is being accepted.
    assign load = sel_any & ((state_q == IDLE) | ready_in);
    assign clr  = load ? idx_to_onehot(sel_idx) : '0;
    assign set  = req_in & {IN_WIDTH{enable}};

    // Set wins over clear, so a re-request of the bit being loaded stays pending.
    assign pend_d = (pend_q & ~clr) | set;
    // Overflow only for bits that remain pending after this edge's clear.
    assign ovf_d  = |(set & pend_q & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            vld_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        bin_q   <= sel_idx;
                        vld_q   <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready_in) begin
                        if (sel_any) begin
                            bin_q <= sel_idx;
                        end else begin
                            vld_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign binary_out   = bin_q;
    assign valid_out    = vld_q;
    assign pending_out  = pend_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_event_encoder_16x4.sv
// Randomized scoreboard bench for event_encoder_16x4 with a set-based reference model.
// Latency: not applicable.
// Backpressure: ready_in driven by the bench, mostly high with random stalls.
module tb_event_encoder_16x4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] req_in;
    logic        ready_in;
    logic [3:0]  binary_out;
    logic        valid_out;
    logic [15:0] pending_out;
    logic        overflow_out;

    int checks = 0;
    int errors = 0;

    // Reference model: a set of pending events plus one output slot.
    bit       m_pend [16];
    bit       m_full;
    int       m_code;
    bit       m_ovf;
    logic [3:0] exp_q [$];

    event_encoder_16x4 dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_in       (req_in),
        .ready_in     (ready_in),
        .binary_out   (binary_out),
        .valid_out    (valid_out),
        .pending_out  (pending_out),
        .overflow_out (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_pend_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_full = 1'b0;
        m_code = 0;
        m_ovf  = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model over one clock edge with the given inputs.
    task automatic model_edge(input logic [15:0] req, input logic en, input logic rdy);
        bit slot_free;
        int lowest;
        slot_free = !m_full || rdy;
        lowest = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i] && lowest < 0) lowest = i;
        end
        m_ovf = 1'b0;
        if (slot_free && lowest >= 0) begin
            m_pend[lowest] = 1'b0;
            m_code = lowest;
            m_full = 1'b1;
            exp_q.push_back(4'(lowest));
        end else if (slot_free) begin
            m_full = 1'b0;
        end
        if (en) begin
            for (int i = 0; i < 16; i++) begin
                if (req[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    // Compare DUT state with the model, then apply the next cycle's inputs.
    task automatic step(input logic [15:0] req, input logic en, input logic rdy);
        @(negedge clk);
        chk("valid_out", int'(valid_out), int'(m_full));
        chk("pending_out", int'(pending_out), int'(model_pend_vec()));
        chk("overflow_out", int'(overflow_out), int'(m_ovf));
        if (m_full) chk("binary_out_held", int'(binary_out), m_code);
        model_edge(req, en, rdy);
        req_in   = req;
        enable   = en;
        ready_in = rdy;
    endtask

    // Monitor: pops an expected code on every transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL transfer_unexpected: got code %0h expected none", binary_out);
                end else begin
                    chk("transfer_code", int'(binary_out), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        req_in   = '0;
        ready_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        repeat (3) step(16'h0000, 1'b1, 1'b1);

        // Single event.
        step(16'h0001, 1'b1, 1'b1);
        repeat (4) step(16'h0000, 1'b1, 1'b1);

        // Multi-hot ordering.
        step(16'h8421, 1'b1, 1'b1);
        repeat (6) step(16'h0000, 1'b1, 1'b1);

        // Backpressure.
        step(16'h0300, 1'b1, 1'b0);
        repeat (6) step(16'h0000, 1'b1, 1'b0);
        repeat (4) step(16'h0000, 1'b1, 1'b1);

        // Overflow / merge.
        step(16'h0030, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        step(16'h0020, 1'b1, 1'b0);
        repeat (3) step(16'h0000, 1'b1, 1'b0);
        repeat (4) step(16'h0000, 1'b1, 1'b1);

        // Enable gating.
        repeat (3) step(16'hFFFF, 1'b0, 1'b1);
        repeat (2) step(16'h0000, 1'b1, 1'b1);

        // Set on the edge that loads the same code.
        step(16'h0008, 1'b1, 1'b1);
        step(16'h0008, 1'b1, 1'b1);
        repeat (4) step(16'h0000, 1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            int sel;
            sel = $urandom_range(0, 9);
            r = 16'($urandom);
            if (sel < 4)      r = '0;
            else if (sel < 7) r = r & 16'($urandom) & 16'($urandom);
            step(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of activity.
        step(16'hA5A5, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_binary", int'(binary_out), 0);
        chk("rst_pending", int'(pending_out), 0);
        chk("rst_overflow", int'(overflow_out), 0);
        model_reset();
        req_in = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(16'h0000, 1'b1, 1'b1);
        step(16'h4002, 1'b1, 1'b1);

        // Drain and make sure nothing expected was left behind.
        repeat (40) step(16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        #4;
        chk("leftover_codes", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
